// File: rtl/xgriscv_fetch_queue_pkg.sv
// Shared constants for the xgriscv fetch queue: default widths and the PC increment.
// Defining XGRISCV_FETCH_PERF_EN adds a 32-bit bubble_cnt output counting decode-starved cycles.
package xgriscv_fetch_queue_pkg;

  localparam int unsigned ADDR_SIZE  = 32;
  localparam int unsigned INSTR_SIZE = 32;
  localparam int unsigned PERF_CNT_W = 32;
  localparam logic [31:0] PC_INCR    = 32'd4;

endpackage

// File: rtl/xgriscv_fetch_queue_fetch_fifo.sv
// Circular buffer for the fetch queue: push, pop and a synchronous clear that drops all entries.
// Storage is reset so the head outputs read as zero straight out of reset.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign doPush = push & ~clear;
  assign doPop  = pop & ~clear & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doPush) begin
      mem[wrPtr] <= wdata;
    end
  end

  // Clear realigns rd onto wr rather than zeroing both, so storage contents stay untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= wrPtr;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  assign rdata = mem[rdPtr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/xgriscv_fetch_queue.sv
// xgriscv fetch front end: PC generator, one-cycle imem request tracking and a prefetch queue.
// Optional XGRISCV_FETCH_PERF_EN adds bubble_cnt (cycles decode was ready but the queue was empty).
module xgriscv_fetch_queue
  import xgriscv_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_SIZE,
  parameter int unsigned       INSTR_W  = INSTR_SIZE,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [ADDR_W-1:0]      pc_out,
  output logic [ADDR_W-1:0]      pcplus4_out,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef XGRISCV_FETCH_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]  bubble_cnt
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  logic               run;
  logic               pend;
  logic [ADDR_W-1:0]  fpc;
  logic [ADDR_W-1:0]  ppc;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic               credit;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] headEntry;

  // Credit counts the in-flight request so its response always finds a free slot.
  assign credit    = ({1'b0, count} + (CNT_W + 1)'(pend)) < (CNT_W + 1)'(DEPTH);
  assign imem_req  = run & ~redirect & credit;
  assign imem_addr = fpc;
  assign push      = pend & ~redirect;
  assign pop       = ~empty & instr_ready & ~redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run  <= 1'b0;
      pend <= 1'b0;
      fpc  <= RESET_PC;
      ppc  <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        fpc  <= redirect_pc;
        pend <= 1'b0;
      end else begin
        pend <= imem_req;
        if (imem_req) begin
          fpc <= fpc + ADDR_W'(PC_INCR);
          ppc <= fpc;
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (redirect),
    .push  (push),
    .wdata ({imem_rdata, ppc}),
    .pop   (pop),
    .rdata (headEntry),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign instr_valid = ~empty;
  assign occupancy   = count;
  assign instr_out   = headEntry[ENTRY_W-1:ADDR_W];
  assign pc_out      = headEntry[ADDR_W-1:0];
  assign pcplus4_out = pc_out + ADDR_W'(PC_INCR);

  // A response landing on a full queue means the credit accounting has broken.
  aNoPushWhenFull: assert property (@(posedge clk) disable iff (!reset) !(push && full));

`ifdef XGRISCV_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (run && instr_ready && !instr_valid) begin
      bubble_cnt <= bubble_cnt + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// Bench for xgriscv_fetch_queue: directed timing scenarios plus randomized traffic against a queue-based model.
module tb_xgriscv_fetch_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcplus4_out;
  logic [2:0]  occupancy;

  logic        wReq;
  logic [31:0] wAddr;
  logic [31:0] wRdata;
  logic        wValid;
  logic [31:0] wInstr;
  logic [31:0] wPc;
  logic [31:0] wPc4;
  logic [1:0]  wOcc;
`ifdef XGRISCV_FETCH_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] wBubble;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] xorKey = '0;

  // Behavioural model: fetch PC, one in-flight request, and the queue contents in order.
  bit          mRun;
  bit          mInflight;
  logic [31:0] mFpc;
  logic [31:0] mInflightPc;
  logic [31:0] mInflightInstr;
  logic [31:0] mBubble;
  entry_t      mq[$];

  always #5 clk = ~clk;

  xgriscv_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out), .pcplus4_out(pcplus4_out), .occupancy(occupancy)
`ifdef XGRISCV_FETCH_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  xgriscv_fetch_queue #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dutw (
    .clk(clk), .reset(reset), .imem_req(wReq), .imem_addr(wAddr), .imem_rdata(wRdata),
    .redirect(1'b0), .redirect_pc(32'h0), .instr_valid(wValid), .instr_ready(1'b1),
    .instr_out(wInstr), .pc_out(wPc), .pcplus4_out(wPc4), .occupancy(wOcc)
`ifdef XGRISCV_FETCH_PERF_EN
    , .bubble_cnt(wBubble)
`endif
  );

  // One-cycle memory; garbage on cycles without a request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ xorKey) : $urandom;
    wRdata     <= wReq ? wAddr : $urandom;
  end

  task automatic modelReset();
    mRun = 1'b0;
    mInflight = 1'b0;
    mFpc = 32'h0;
    mInflightPc = '0;
    mInflightInstr = '0;
    mBubble = '0;
    mq.delete();
  endtask

  // Advance one clock edge, updating the model from the inputs held before the edge.
  task automatic cycle();
    bit          rd;
    bit          rdy;
    bit          req;
    logic [31:0] rpc;
    logic [31:0] key;
    entry_t      e;
    rd  = redirect;
    rdy = instr_ready;
    rpc = redirect_pc;
    key = xorKey;
    req = mRun && !rd && (mq.size() + int'(mInflight) < DEPTH);
    @(posedge clk);
    if (!reset) begin
      modelReset();
    end else begin
      if (mRun && rdy && mq.size() == 0) mBubble = mBubble + 32'd1;
      if (rd) begin
        mq.delete();
        mInflight = 1'b0;
        mFpc = rpc;
      end else begin
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (mInflight) begin
          e.pc = mInflightPc;
          e.instr = mInflightInstr;
          mq.push_back(e);
        end
        mInflight = req;
        if (req) begin
          mInflightPc = mFpc;
          mInflightInstr = mFpc ^ key;
          mFpc = mFpc + 32'd4;
        end
      end
      mRun = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0ABC;
    modelReset();
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL reset_valid_occ got %0b/%0d exp 0/0", instr_valid, occupancy); end
    checks++; if (instr_out !== 32'h0 || pc_out !== 32'h0 || pcplus4_out !== 32'd4) begin errors++; $display("FAIL reset_head got %h/%h/%h exp 0/0/4", instr_out, pc_out, pcplus4_out); end
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL prerun_req got %0b exp 0", imem_req); end
    cycle();
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL cycle0_req got %0b@%h exp 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_startup();
    xorKey = '0;
    applyReset();
    for (int k = 0; k < 10; k++) begin
      cycle();
      instr_ready = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL start_req c%0d got %0b@%h exp 1@%h", k, imem_req, imem_addr, 32'(4 * k)); end
      checks++; if (instr_valid !== (k >= 2)) begin errors++; $display("FAIL start_valid c%0d got %0b", k, instr_valid); end
      if (k >= 2) begin
        checks++;
        if (pc_out !== 32'(4 * (k - 2)) || instr_out !== 32'(4 * (k - 2)) || pcplus4_out !== 32'(4 * (k - 1))) begin
          errors++; $display("FAIL start_head c%0d got pc %h ins %h p4 %h exp pc %h", k, pc_out, instr_out, pcplus4_out, 32'(4 * (k - 2)));
        end
      end
`ifdef XGRISCV_FETCH_PERF_EN
      if (k == 2) begin
        checks++; if (bubble_cnt !== 32'd2) begin errors++; $display("FAIL start_bubble got %0d exp 2", bubble_cnt); end
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int nReq;
    nReq = 0;
    xorKey = 32'h5A5A_0000;
    applyReset();
    for (int k = 0; k < 10; k++) begin
      cycle();
      instr_ready = 1'b0;
      #1;
      if (imem_req === 1'b1) begin
        checks++; if (imem_addr !== 32'(4 * nReq)) begin errors++; $display("FAIL bp_addr got %h exp %h", imem_addr, 32'(4 * nReq)); end
        nReq++;
      end
    end
    checks++; if (nReq != 4) begin errors++; $display("FAIL bp_reqcount got %0d exp 4", nReq); end
    checks++; if (occupancy !== 3'd4 || imem_req !== 1'b0) begin errors++; $display("FAIL bp_full got occ %0d req %0b exp 4/0", occupancy, imem_req); end
    for (int j = 0; j < 5; j++) begin
      cycle();
      instr_ready = 1'b1;
      #1;
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'(4 * j) || instr_out !== (32'(4 * j) ^ 32'h5A5A_0000)) begin
        errors++; $display("FAIL bp_drain j%0d got v%0b pc %h ins %h exp pc %h", j, instr_valid, pc_out, instr_out, 32'(4 * j));
      end
    end
  endtask

  task automatic test_redirect();
    xorKey = 32'h3C3C_0000;
    applyReset();
    for (int k = 0; k < 3; k++) begin
      cycle();
      instr_ready = 1'b0;
    end
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    checks++; if (occupancy !== 3'd2 || imem_req !== 1'b0) begin errors++; $display("FAIL redir_cycle got occ %0d req %0b exp 2/0", occupancy, imem_req); end
    cycle();
    redirect = 1'b0;
    instr_ready = 1'b1;
    #1;
    checks++; if (occupancy !== 3'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got occ %0d v %0b exp 0/0", occupancy, instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_req got %0b@%h exp 1@100", imem_req, imem_addr); end
    cycle();
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_t2 got v %0b exp 0", instr_valid); end
    for (int j = 0; j < 5; j++) begin
      cycle();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== (32'h100 + 32'(4 * j)) || instr_out !== ((32'h100 + 32'(4 * j)) ^ 32'h3C3C_0000)) begin
        errors++; $display("FAIL redir_stream j%0d got v%0b pc %h ins %h exp pc %h", j, instr_valid, pc_out, instr_out, 32'h100 + 32'(4 * j));
      end
    end
  endtask

  task automatic test_redirect_first();
    xorKey = '0;
    applyReset();
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rfirst_req got %0b exp 0", imem_req); end
    cycle();
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rfirst_addr got %0b@%h exp 1@40", imem_req, imem_addr); end
    cycle();
    cycle();
    #1;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h40) begin errors++; $display("FAIL rfirst_head got v%0b pc %h exp 1/40", instr_valid, pc_out); end
  endtask

  task automatic test_redirect_pop();
    int nXfer;
    nXfer = 0;
    xorKey = 32'h0F0F_0000;
    applyReset();
    for (int k = 0; k < 10; k++) begin
      cycle();
      instr_ready = 1'b1;
      redirect = (k == 5);
      redirect_pc = 32'h0000_0200;
      #1;
      if (instr_valid === 1'b1 && instr_ready && !redirect) nXfer++;
      if (k == 5) begin
        checks++; if (pc_out !== 32'd12) begin errors++; $display("FAIL rpop_head got %h exp c", pc_out); end
      end
      if (k == 8) begin
        checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h200) begin errors++; $display("FAIL rpop_next got v%0b pc %h exp 1/200", instr_valid, pc_out); end
      end
    end
    checks++; if (nXfer != 5) begin errors++; $display("FAIL rpop_xfers got %0d exp 5", nXfer); end
  endtask

  task automatic test_wrap();
    applyReset();
    #1;
    checks++; if (wReq !== 1'b0 || wAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset got %0b@%h", wReq, wAddr); end
    cycle();
    #1;
    checks++; if (wReq !== 1'b1 || wAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_c0 got %0b@%h exp 1@fffffffc", wReq, wAddr); end
    cycle();
    #1;
    checks++; if (wReq !== 1'b1 || wAddr !== 32'h0) begin errors++; $display("FAIL wrap_c1 got %0b@%h exp 1@0", wReq, wAddr); end
    cycle();
    #1;
    checks++; if (wValid !== 1'b1 || wPc !== 32'hFFFF_FFFC || wPc4 !== 32'h0 || wInstr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head got v%0b pc %h p4 %h ins %h", wValid, wPc, wPc4, wInstr); end
    checks++; if (wReq !== 1'b0 || wOcc !== 2'd1) begin errors++; $display("FAIL wrap_credit got req %0b occ %0d exp 0/1", wReq, wOcc); end
`ifdef XGRISCV_FETCH_PERF_EN
    checks++; if (wBubble !== 32'd2) begin errors++; $display("FAIL wrap_bubble got %0d exp 2", wBubble); end
`endif
    cycle();
    #1;
    checks++; if (wPc !== 32'h0 || wPc4 !== 32'd4 || wReq !== 1'b1 || wAddr !== 32'd4) begin errors++; $display("FAIL wrap_c3 got pc %h p4 %h req %0b@%h", wPc, wPc4, wReq, wAddr); end
    cycle();
    #1;
    checks++; if (wValid !== 1'b0) begin errors++; $display("FAIL wrap_gap got v%0b exp 0", wValid); end
    cycle();
    #1;
    checks++; if (wValid !== 1'b1 || wPc !== 32'd4) begin errors++; $display("FAIL wrap_c5 got v%0b pc %h exp 1/4", wValid, wPc); end
  endtask

  task automatic test_reset_midstream();
    xorKey = 32'h7E00_0000;
    applyReset();
    for (int k = 0; k < 5; k++) begin
      cycle();
      instr_ready = 1'b0;
    end
    #1;
    checks++; if (occupancy !== 3'd3 || instr_out !== 32'h7E00_0000) begin errors++; $display("FAIL mid_pre got occ %0d ins %h exp 3/7e000000", occupancy, instr_out); end
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL mid_async got req %0b addr %h v %0b occ %0d", imem_req, imem_addr, instr_valid, occupancy); end
    checks++; if (instr_out !== 32'h0 || pc_out !== 32'h0 || pcplus4_out !== 32'd4) begin errors++; $display("FAIL mid_head got %h/%h/%h exp 0/0/4", instr_out, pc_out, pcplus4_out); end
    cycle();
    reset = 1'b1;
    instr_ready = 1'b1;
    cycle();
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got %0b@%h exp 1@0", imem_req, imem_addr); end
    cycle();
    cycle();
    #1;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h7E00_0000) begin errors++; $display("FAIL mid_first got v%0b pc %h ins %h", instr_valid, pc_out, instr_out); end
  endtask

  task automatic test_random();
    bit expReq;
    int pct;
    xorKey = $urandom;
    applyReset();
    for (int k = 0; k < 900; k++) begin
      cycle();
      pct = ((k / 60) % 3 == 0) ? 15 : (((k / 60) % 3 == 1) ? 70 : 100);
      instr_ready = ($urandom_range(99) < pct);
      redirect = ($urandom_range(19) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(3))) : ($urandom & 32'hFFFF_FFFC);
      #1;
      expReq = mRun && !redirect && (mq.size() + int'(mInflight) < DEPTH);
      checks++; if (imem_req !== expReq) begin errors++; $display("FAIL rnd_req k%0d got %0b exp %0b", k, imem_req, expReq); end
      checks++; if (imem_addr !== mFpc) begin errors++; $display("FAIL rnd_addr k%0d got %h exp %h", k, imem_addr, mFpc); end
      checks++; if (instr_valid !== (mq.size() != 0) || occupancy !== 3'(mq.size())) begin errors++; $display("FAIL rnd_occ k%0d got v%0b occ %0d exp %0d", k, instr_valid, occupancy, mq.size()); end
      if (mq.size() != 0) begin
        checks++;
        if (pc_out !== mq[0].pc || instr_out !== mq[0].instr || pcplus4_out !== (mq[0].pc + 32'd4)) begin
          errors++; $display("FAIL rnd_head k%0d got pc %h ins %h p4 %h exp pc %h ins %h", k, pc_out, instr_out, pcplus4_out, mq[0].pc, mq[0].instr);
        end
      end
`ifdef XGRISCV_FETCH_PERF_EN
      checks++; if (bubble_cnt !== mBubble) begin errors++; $display("FAIL rnd_bubble k%0d got %0d exp %0d", k, bubble_cnt, mBubble); end
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_redirect_first();
    test_redirect_pop();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
